// File: rtl/mips_cpu_hilo_pkg.sv
// Shared definitions for the HI/LO issue controller.
//   - Funct codes of the HI/LO-class instructions, plus FN_NOP, which is the
//     neutral opcode the multiply/divide unit ignores.
//   - State type of the issue sequencer.
package mips_cpu_hilo_pkg;

    localparam logic [5:0] FN_NOP   = 6'b000000;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MT,
        ST_MULT,
        ST_DIV_START,
        ST_DIV_RUN,
        ST_DIV_FIN
    } hilo_issue_state_t;

endpackage

// File: rtl/mips_cpu_hilo_issue.sv
// Issue/sequencing controller between decode/execute and the HI/LO
// multiply-divide unit. Accepts mthi/mtlo/mult/multu/div/divu/mfhi/mflo,
// drives the unit's opcode/a/b/valid_in for as long as each operation needs,
// stalls decode while busy and returns mfhi/mflo data.
//
// Ports:
//   clk, reset       clock; asynchronous active-low reset
//   instr_valid      decode presents a HI/LO-class instruction
//   funct            instruction funct field
//   rs_val, rt_val   operands
//   stall            combinational: instr_valid while not idle
//   busy             sequencer not idle
//   mf_valid         one-cycle pulse, mf_result valid
//   mf_result        mfhi/mflo data
//   err              sticky divide-timeout flag
//   hilo_opcode      opcode to the unit (FN_NOP when idle)
//   hilo_a, hilo_b   operands to the unit
//   hilo_valid_in    divide start strobe to the unit
//   hilo_valid_out   divide completion from the unit
//   hi_reg, lo_reg   unit's HI/LO registers
module mips_cpu_hilo_issue
    import mips_cpu_hilo_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 2,
    parameter int unsigned DIV_TIMEOUT = 48
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        stall,
    output logic        busy,
    output logic        mf_valid,
    output logic [31:0] mf_result,
    output logic        err,
    output logic [5:0]  hilo_opcode,
    output logic [31:0] hilo_a,
    output logic [31:0] hilo_b,
    output logic        hilo_valid_in,
    input  logic        hilo_valid_out,
    input  logic [31:0] hi_reg,
    input  logic [31:0] lo_reg
);

    localparam int unsigned CNT_W  = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
    localparam int unsigned TCNT_W = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;

    hilo_issue_state_t state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [5:0]        opcode_q, opcode_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic              vin_q, vin_d;
    logic              mfv_q, mfv_d;
    logic [31:0]       mfr_q, mfr_d;
    logic              err_q, err_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tcnt_d   = tcnt_q;
        opcode_d = opcode_q;
        a_d      = a_q;
        b_d      = b_q;
        vin_d    = 1'b0;
        mfv_d    = 1'b0;
        mfr_d    = mfr_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    case (funct)
                        FN_MTHI, FN_MTLO: begin
                            opcode_d = funct;
                            a_d      = rs_val;
                            state_d  = ST_MT;
                        end
                        FN_MULT, FN_MULTU: begin
                            opcode_d = funct;
                            a_d      = rs_val;
                            b_d      = rt_val;
                            cnt_d    = CNT_W'(MULT_CYCLES - 1);
                            state_d  = ST_MULT;
                        end
                        FN_DIV, FN_DIVU: begin
                            opcode_d = funct;
                            a_d      = rs_val;
                            b_d      = rt_val;
                            vin_d    = 1'b1;
                            state_d  = ST_DIV_START;
                        end
                        FN_MFHI: begin
                            mfv_d = 1'b1;
                            mfr_d = hi_reg;
                        end
                        FN_MFLO: begin
                            mfv_d = 1'b1;
                            mfr_d = lo_reg;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MT: begin
                opcode_d = FN_NOP;
                state_d  = ST_IDLE;
            end
            ST_MULT: begin
                if (cnt_q == '0) begin
                    opcode_d = FN_NOP;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DIV_START: begin
                // valid_out may still be high from the previous divide, so it
                // is not looked at until the unit has seen this start.
                tcnt_d  = '0;
                state_d = ST_DIV_RUN;
            end
            ST_DIV_RUN: begin
                if (hilo_valid_out) begin
                    state_d = ST_DIV_FIN;
                end else if (tcnt_q == TCNT_W'(DIV_TIMEOUT - 1)) begin
                    err_d    = 1'b1;
                    opcode_d = FN_NOP;
                    state_d  = ST_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            ST_DIV_FIN: begin
                // Opcode and operands stay up through the unit's finish cycle
                // (signed divide fixes up signs from a there).
                opcode_d = FN_NOP;
                state_d  = ST_IDLE;
            end
            default: begin
                opcode_d = FN_NOP;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            tcnt_q   <= '0;
            opcode_q <= FN_NOP;
            a_q      <= '0;
            b_q      <= '0;
            vin_q    <= 1'b0;
            mfv_q    <= 1'b0;
            mfr_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tcnt_q   <= tcnt_d;
            opcode_q <= opcode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            vin_q    <= vin_d;
            mfv_q    <= mfv_d;
            mfr_q    <= mfr_d;
            err_q    <= err_d;
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign stall         = instr_valid && busy;
    assign mf_valid      = mfv_q;
    assign mf_result     = mfr_q;
    assign err           = err_q;
    assign hilo_opcode   = opcode_q;
    assign hilo_a        = a_q;
    assign hilo_b        = b_q;
    assign hilo_valid_in = vin_q;

endmodule

// File: tb/tb_mips_cpu_hilo_issue.sv
// Bench for mips_cpu_hilo_issue: a small behavioural HI/LO unit drives the
// DUT's unit-side inputs, an architectural model predicts every DUT output
// each cycle, and directed sequences add literal expectations.
module tb_mips_cpu_hilo_issue;
    import mips_cpu_hilo_pkg::*;

    localparam int TO      = 48;
    localparam int DIV_OCC = 37;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic [5:0]  funct = 6'd0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        stall, busy, mf_valid, err, hilo_valid_in;
    logic [31:0] mf_result, hilo_a, hilo_b;
    logic [5:0]  hilo_opcode;
    logic        hilo_valid_out;
    logic [31:0] hi_reg, lo_reg;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips_cpu_hilo_issue #(
        .MULT_CYCLES(2),
        .DIV_TIMEOUT(TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .funct         (funct),
        .rs_val        (rs_val),
        .rt_val        (rt_val),
        .stall         (stall),
        .busy          (busy),
        .mf_valid      (mf_valid),
        .mf_result     (mf_result),
        .err           (err),
        .hilo_opcode   (hilo_opcode),
        .hilo_a        (hilo_a),
        .hilo_b        (hilo_b),
        .hilo_valid_in (hilo_valid_in),
        .hilo_valid_out(hilo_valid_out),
        .hi_reg        (hi_reg),
        .lo_reg        (lo_reg)
    );

    function automatic logic [63:0] mul_s(input logic [31:0] a, input logic [31:0] b);
        return {{32{a[31]}}, a} * {{32{b[31]}}, b};
    endfunction

    function automatic logic [63:0] mul_u(input logic [31:0] a, input logic [31:0] b);
        return {32'd0, a} * {32'd0, b};
    endfunction

    // {remainder, quotient}
    function automatic logic [63:0] div_s(input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb, q, r;
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
        return {r, q};
    endfunction

    function automatic logic [63:0] div_u(input logic [31:0] a, input logic [31:0] b);
        return {a % b, a / b};
    endfunction

    // ---------------- behavioural HI/LO unit ----------------
    logic [31:0] u_hi = '0, u_lo = '0;
    logic [63:0] u_p = '0;
    logic        u_mph = 1'b0, u_vout = 1'b0, u_fin = 1'b0, u_stub = 1'b0;
    int          u_dcnt = 0;

    assign hi_reg         = u_hi;
    assign lo_reg         = u_lo;
    assign hilo_valid_out = u_vout;

    always @(posedge clk) begin
        if (hilo_opcode == FN_MTHI) u_hi <= hilo_a;
        if (hilo_opcode == FN_MTLO) u_lo <= hilo_a;
        if (hilo_opcode == FN_MULT || hilo_opcode == FN_MULTU) begin
            if (!u_mph) begin
                u_p   <= (hilo_opcode == FN_MULT) ? mul_s(hilo_a, hilo_b) : mul_u(hilo_a, hilo_b);
                u_mph <= 1'b1;
            end else begin
                u_hi  <= u_p[63:32];
                u_lo  <= u_p[31:0];
                u_mph <= 1'b0;
            end
        end else begin
            u_mph <= 1'b0;
        end
        if (hilo_valid_in) begin
            u_dcnt <= 34;
            u_vout <= 1'b0;
            u_fin  <= 1'b0;
        end else if (u_dcnt > 0) begin
            u_dcnt <= u_dcnt - 1;
            if (u_dcnt == 1 && !u_stub) begin
                u_vout <= 1'b1;
                u_fin  <= 1'b1;
            end
        end else if (u_fin) begin
            u_fin <= 1'b0;
            if (hilo_opcode == FN_DIV) begin
                u_hi <= div_s(hilo_a, hilo_b) >> 32;
                u_lo <= div_s(hilo_a, hilo_b) & 64'hFFFF_FFFF;
            end else if (hilo_opcode == FN_DIVU) begin
                u_hi <= div_u(hilo_a, hilo_b) >> 32;
                u_lo <= div_u(hilo_a, hilo_b) & 64'hFFFF_FFFF;
            end
        end
    end

    // ---------------- architectural model ----------------
    int          m_left;
    logic        m_vin, m_mfv, m_err, m_chkb, m_to;
    logic [31:0] m_mfr, m_a, m_b;
    logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
    logic [5:0]  m_opc;
    logic [1:0]  m_pw;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_left <= 0;     m_vin <= 1'b0;  m_mfv <= 1'b0;  m_mfr <= '0;
            m_err  <= 1'b0;  m_opc <= FN_NOP; m_a <= '0;     m_b <= '0;
            m_chkb <= 1'b0;  m_to <= 1'b0;   m_pw <= 2'b00;
        end else begin
            m_mfv <= 1'b0;
            m_vin <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_opc <= FN_NOP;
                    if (m_to) m_err <= 1'b1;
                    else begin
                        if (m_pw[1]) m_hi <= m_phi;
                        if (m_pw[0]) m_lo <= m_plo;
                    end
                end
            end else if (instr_valid) begin
                case (funct)
                    FN_MTHI, FN_MTLO: begin
                        m_left <= 1; m_opc <= funct; m_a <= rs_val; m_chkb <= 1'b0; m_to <= 1'b0;
                        m_pw   <= (funct == FN_MTHI) ? 2'b10 : 2'b01;
                        m_phi  <= rs_val;
                        m_plo  <= rs_val;
                    end
                    FN_MULT, FN_MULTU: begin
                        m_left <= 2; m_opc <= funct; m_a <= rs_val; m_b <= rt_val;
                        m_chkb <= 1'b1; m_to <= 1'b0; m_pw <= 2'b11;
                        {m_phi, m_plo} <= (funct == FN_MULT) ? mul_s(rs_val, rt_val) : mul_u(rs_val, rt_val);
                    end
                    FN_DIV, FN_DIVU: begin
                        m_left <= u_stub ? TO + 1 : DIV_OCC; m_vin <= 1'b1;
                        m_opc <= funct; m_a <= rs_val; m_b <= rt_val;
                        m_chkb <= 1'b1; m_to <= u_stub; m_pw <= 2'b11;
                        {m_phi, m_plo} <= (funct == FN_DIV) ? div_s(rs_val, rt_val) : div_u(rs_val, rt_val);
                    end
                    FN_MFHI: begin m_mfv <= 1'b1; m_mfr <= m_hi; end
                    FN_MFLO: begin m_mfv <= 1'b1; m_mfr <= m_lo; end
                    default: ;
                endcase
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_left > 0));
        chk("stall", 32'(stall), 32'(instr_valid && m_left > 0));
        chk("valid_in", 32'(hilo_valid_in), 32'(m_vin));
        chk("opcode", 32'(hilo_opcode), 32'(m_opc));
        chk("err", 32'(err), 32'(m_err));
        chk("mf_valid", 32'(mf_valid), 32'(m_mfv));
        if (m_left > 0) chk("hilo_a", hilo_a, m_a);
        if (m_left > 0 && m_chkb) chk("hilo_b", hilo_b, m_b);
        if (m_mfv) chk("mf_result", mf_result, m_mfr);
    end

    // ---------------- directed helpers ----------------
    // Presents an instruction and holds it until accepted (bounded).
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, output int n);
        logic acc;
        n = 0;
        instr_valid = 1'b1; funct = f; rs_val = a; rt_val = b;
        do begin
            acc = (m_left == 0);
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 300);
        instr_valid = 1'b0; funct = FN_NOP;
        chk("issue_accept", 32'(acc), 32'd1);
    endtask

    task automatic busy_len(input string nm, input int exp_len, input int exp_vin);
        int cnt, vin;
        cnt = 0;
        vin = 0;
        while (busy === 1'b1 && cnt < 300) begin
            cnt++;
            if (hilo_valid_in === 1'b1) vin++;
            @(posedge clk); #1;
        end
        chk({nm, "_busy_cycles"}, 32'(cnt), 32'(exp_len));
        chk({nm, "_valid_in_cycles"}, 32'(vin), 32'(exp_vin));
    endtask

    task automatic mf(input string nm, input logic [5:0] f, input logic [31:0] exp);
        int n;
        issue(f, '0, '0, n);
        @(negedge clk);
        chk({nm, "_mf_valid"}, 32'(mf_valid), 32'd1);
        chk({nm, "_mf_result"}, mf_result, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_opcode", 32'(hilo_opcode), 32'(FN_NOP));
        chk("rst_a", hilo_a, 32'd0);
        chk("rst_b", hilo_b, 32'd0);
        chk("rst_mf_result", mf_result, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk); #3 reset = 1'b1;
        @(posedge clk); #1;

        // mthi then mfhi back-to-back: one stall cycle
        issue(FN_MTHI, 32'h1234_5678, '0, n);
        issue(FN_MFHI, '0, '0, n);
        chk("mfhi_wait_cycles", 32'(n), 32'd2);
        @(negedge clk);
        chk("mthi_mfhi_result", mf_result, 32'h1234_5678);
        issue(FN_MTLO, 32'hA5A5_0F0F, '0, n);
        mf("mtlo", FN_MFLO, 32'hA5A5_0F0F);

        // undefined funct while idle: ignored
        instr_valid = 1'b1; funct = 6'b100000; rs_val = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        instr_valid = 1'b0; funct = FN_NOP;
        chk("bad_funct_busy", 32'(busy), 32'd0);
        mf("bad_funct_keep_lo", FN_MFLO, 32'hA5A5_0F0F);

        // mult / multu
        issue(FN_MULT, 32'hFFFF_FFFD, 32'd7, n);
        busy_len("mult", 2, 0);
        mf("mult_lo", FN_MFLO, 32'hFFFF_FFEB);
        mf("mult_hi", FN_MFHI, 32'hFFFF_FFFF);
        issue(FN_MULTU, 32'hFFFF_FFFF, 32'd2, n);
        busy_len("multu", 2, 0);
        mf("multu_hi", FN_MFHI, 32'h0000_0001);
        mf("multu_lo", FN_MFLO, 32'hFFFF_FFFE);

        // divu / div
        issue(FN_DIVU, 32'd100, 32'd7, n);
        busy_len("divu", 37, 1);
        mf("divu_lo", FN_MFLO, 32'd14);
        mf("divu_hi", FN_MFHI, 32'd2);
        issue(FN_DIV, 32'hFFFF_FF9C, 32'd7, n);
        busy_len("div", 37, 1);
        mf("div_lo", FN_MFLO, 32'hFFFF_FFF2);
        mf("div_hi", FN_MFHI, 32'hFFFF_FFFE);

        // mflo presented during a divide: stalled until idle
        issue(FN_DIVU, 32'd100, 32'd7, n);
        repeat (2) @(posedge clk);
        #1;
        issue(FN_MFLO, '0, '0, n);
        chk("mflo_during_div_wait", 32'(n), 32'd36);
        @(negedge clk);
        chk("mflo_during_div_result", mf_result, 32'd14);

        // async reset in the middle of a divide
        issue(FN_DIVU, 32'd100, 32'd7, n);
        repeat (9) @(posedge clk);
        #1 instr_valid = 1'b1; funct = FN_MFHI;
        #1 chk("pre_reset_stall", 32'(stall), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_valid_in", 32'(hilo_valid_in), 32'd0);
        chk("reset_opcode", 32'(hilo_opcode), 32'(FN_NOP));
        instr_valid = 1'b0; funct = FN_NOP;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk); #1;
        issue(FN_MULTU, 32'd3, 32'd5, n);
        busy_len("multu_after_reset", 2, 0);
        mf("post_reset_lo", FN_MFLO, 32'd15);
        mf("post_reset_hi", FN_MFHI, 32'd0);
        repeat (30) @(posedge clk);
        #1;

        // unit never completes: timeout
        u_stub = 1'b1;
        issue(FN_DIVU, 32'd100, 32'd7, n);
        busy_len("div_timeout", TO + 1, 1);
        chk("timeout_err", 32'(err), 32'd1);
        u_stub = 1'b0;
        issue(FN_MTHI, 32'hCAFE_F00D, '0, n);
        mf("after_timeout", FN_MFHI, 32'hCAFE_F00D);
        chk("err_sticky", 32'(err), 32'd1);
        @(posedge clk); #3 reset = 1'b0;
        #1 chk("err_cleared", 32'(err), 32'd0);
        @(posedge clk); #3 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
